lsu_sq_fwd: RTL and testbench

Parametrised store queue for the LSU. It holds speculative stores in program order and marks them committed on ROB retirement. Committed stores drain in order to the dcache write port through a valid/stall handshake. It adds combinational store-to-load forwarding, so loads that hit a queued store are satisfied without a dcache access, and loads that partially overlap a queued store are flagged for replay.

---
 rtl/lsu_sq_fwd_if.sv | 50 +++++
 rtl/lsu_sq_fwd.sv | 134 +++++++++++++
 tb/tb_lsu_sq_fwd.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_sq_fwd_if.sv
// Store-queue port bundle: allocation, ROB commit, dcache drain and load-forwarding lookup.
// The master side is the LSU/ROB/dcache environment and the slave side is the store queue.
interface lsu_sq_fwd_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned TAG_WIDTH  = 6
);
  localparam int unsigned BS_WIDTH = DATA_WIDTH / 8;

  logic                  i_flush;
  logic                  o_full;
  logic                  o_empty;

  logic                  i_alloc_en;
  logic [TAG_WIDTH-1:0]  i_alloc_tag;
  logic [ADDR_WIDTH-1:0] i_alloc_addr;
  logic [DATA_WIDTH-1:0] i_alloc_data;
  logic [BS_WIDTH-1:0]   i_alloc_byte_sel;

  logic                  i_rob_retire_en;
  logic [TAG_WIDTH-1:0]  i_rob_retire_tag;

  logic                  o_retire_en;
  logic [ADDR_WIDTH-1:0] o_retire_addr;
  logic [DATA_WIDTH-1:0] o_retire_data;
  logic [BS_WIDTH-1:0]   o_retire_byte_sel;
  logic [TAG_WIDTH-1:0]  o_retire_tag;
  logic                  i_retire_stall;

  logic                  i_fwd_en;
  logic [ADDR_WIDTH-1:0] i_fwd_addr;
  logic [BS_WIDTH-1:0]   i_fwd_byte_sel;
  logic                  o_fwd_hit;
  logic                  o_fwd_conflict;
  logic [DATA_WIDTH-1:0] o_fwd_data;

  modport master (
    output i_flush, i_alloc_en, i_alloc_tag, i_alloc_addr, i_alloc_data, i_alloc_byte_sel,
           i_rob_retire_en, i_rob_retire_tag, i_retire_stall, i_fwd_en, i_fwd_addr, i_fwd_byte_sel,
    input  o_full, o_empty, o_retire_en, o_retire_addr, o_retire_data, o_retire_byte_sel,
           o_retire_tag, o_fwd_hit, o_fwd_conflict, o_fwd_data
  );

  modport slave (
    input  i_flush, i_alloc_en, i_alloc_tag, i_alloc_addr, i_alloc_data, i_alloc_byte_sel,
           i_rob_retire_en, i_rob_retire_tag, i_retire_stall, i_fwd_en, i_fwd_addr, i_fwd_byte_sel,
    output o_full, o_empty, o_retire_en, o_retire_addr, o_retire_data, o_retire_byte_sel,
           o_retire_tag, o_fwd_hit, o_fwd_conflict, o_fwd_data
  );
endinterface

// File: rtl/lsu_sq_fwd.sv
// LSU store queue: in-order speculative stores, commit on ROB retire, in-order drain to the
// dcache, and combinational youngest-match store-to-load forwarding.
module lsu_sq_fwd #(
  parameter int unsigned SQ_DEPTH   = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned TAG_WIDTH  = 6
) (
  input  logic          clk,
  input  logic          rst,
  lsu_sq_fwd_if.slave   sq
);
  localparam int unsigned BS_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned OFS      = $clog2(BS_WIDTH);
  localparam int unsigned PTR_W    = $clog2(SQ_DEPTH);

  typedef logic [PTR_W:0]   ptr_t;
  typedef logic [PTR_W-1:0] idx_t;

  logic [SQ_DEPTH-1:0]   valid_q, committed_q;
  logic [SQ_DEPTH-1:0]   valid_d, committed_d, commit_hit;
  logic [TAG_WIDTH-1:0]  tag_q   [SQ_DEPTH];
  logic [ADDR_WIDTH-1:0] addr_q  [SQ_DEPTH];
  logic [DATA_WIDTH-1:0] data_q  [SQ_DEPTH];
  logic [BS_WIDTH-1:0]   bsel_q  [SQ_DEPTH];

  ptr_t head_q, tail_q, count_q, n_comm;
  idx_t head_idx, tail_idx, fwd_idx;

  logic alloc_acc, drain_acc, retire_en;
  logic fwd_found;
  logic [BS_WIDTH-1:0]   fwd_ov, fwd_ov_sel;
  logic [DATA_WIDTH-1:0] fwd_data_sel;
  logic                  unused_fwd_addr;

  assign head_idx = head_q[PTR_W-1:0];
  assign tail_idx = tail_q[PTR_W-1:0];

  assign sq.o_full  = (count_q == ptr_t'(SQ_DEPTH));
  assign sq.o_empty = (count_q == '0);

  assign retire_en            = valid_q[head_idx] & committed_q[head_idx];
  assign sq.o_retire_en       = retire_en;
  assign sq.o_retire_addr     = addr_q[head_idx];
  assign sq.o_retire_data     = data_q[head_idx];
  assign sq.o_retire_byte_sel = bsel_q[head_idx];
  assign sq.o_retire_tag      = tag_q[head_idx];

  // A flush drops any same-cycle alloc; a full queue drops it even if a drain frees a slot.
  assign alloc_acc = sq.i_alloc_en & ~sq.o_full & ~sq.i_flush;
  assign drain_acc = retire_en & ~sq.i_retire_stall;

  assign unused_fwd_addr = ^sq.i_fwd_addr;

  always_comb begin
    commit_hit = '0;
    for (int unsigned i = 0; i < SQ_DEPTH; i++) begin
      if (sq.i_rob_retire_en && valid_q[i] && (tag_q[i] == sq.i_rob_retire_tag))
        commit_hit[i] = 1'b1;
    end
  end

  // Same-cycle commit is folded in before the flush so that entry survives it.
  always_comb begin
    valid_d     = valid_q;
    committed_d = committed_q | commit_hit;
    n_comm      = '0;
    for (int unsigned i = 0; i < SQ_DEPTH; i++)
      n_comm = n_comm + ptr_t'(valid_q[i] & committed_d[i]);
    if (sq.i_flush)
      valid_d = valid_q & committed_d;
    committed_d = committed_d & valid_d;
    if (alloc_acc) begin
      valid_d[tail_idx]     = 1'b1;
      committed_d[tail_idx] = 1'b0;
    end
    if (drain_acc) begin
      valid_d[head_idx]     = 1'b0;
      committed_d[head_idx] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      valid_q     <= '0;
      committed_q <= '0;
    end else begin
      valid_q     <= valid_d;
      committed_q <= committed_d;
      if (alloc_acc) begin
        tag_q[tail_idx]  <= sq.i_alloc_tag;
        addr_q[tail_idx] <= sq.i_alloc_addr;
        data_q[tail_idx] <= sq.i_alloc_data;
        bsel_q[tail_idx] <= sq.i_alloc_byte_sel;
      end
      if (drain_acc)
        head_q <= head_q + ptr_t'(1);
      if (sq.i_flush) begin
        tail_q  <= head_q + n_comm;
        count_q <= n_comm - ptr_t'(drain_acc);
      end else begin
        if (alloc_acc)
          tail_q <= tail_q + ptr_t'(1);
        count_q <= count_q + ptr_t'(alloc_acc) - ptr_t'(drain_acc);
      end
    end
  end

  // Walk oldest to youngest from head; the last match seen is the youngest overlapping store.
  always_comb begin
    fwd_found    = 1'b0;
    fwd_ov_sel   = '0;
    fwd_data_sel = '0;
    fwd_idx      = '0;
    fwd_ov       = '0;
    for (int unsigned i = 0; i < SQ_DEPTH; i++) begin
      fwd_idx = head_idx + idx_t'(i);
      fwd_ov  = bsel_q[fwd_idx] & sq.i_fwd_byte_sel;
      if (valid_q[fwd_idx] && (fwd_ov != '0) &&
          (addr_q[fwd_idx][ADDR_WIDTH-1:OFS] == sq.i_fwd_addr[ADDR_WIDTH-1:OFS])) begin
        fwd_found    = 1'b1;
        fwd_ov_sel   = fwd_ov;
        fwd_data_sel = data_q[fwd_idx];
      end
    end
  end

  assign sq.o_fwd_hit      = sq.i_fwd_en & fwd_found & (fwd_ov_sel == sq.i_fwd_byte_sel);
  assign sq.o_fwd_conflict = sq.i_fwd_en & fwd_found & (fwd_ov_sel != sq.i_fwd_byte_sel);
  assign sq.o_fwd_data     = fwd_data_sel;
endmodule

// File: tb/tb_lsu_sq_fwd.sv
// Directed self-checking bench for lsu_sq_fwd: fill/full, stalled drain, forwarding,
// flush priority and a sustained alloc+drain run across the pointer wrap.
module tb_lsu_sq_fwd;
  localparam int unsigned SQ_DEPTH   = 8;
  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned ADDR_WIDTH = 32;
  localparam int unsigned TAG_WIDTH  = 6;

  logic clk = 1'b0;
  logic rst;
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  lsu_sq_fwd_if #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .TAG_WIDTH (TAG_WIDTH)
  ) sq_if ();

  lsu_sq_fwd #(
    .SQ_DEPTH  (SQ_DEPTH),
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .TAG_WIDTH (TAG_WIDTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sq (sq_if)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    sq_if.i_flush          = 1'b0;
    sq_if.i_alloc_en       = 1'b0;
    sq_if.i_alloc_tag      = '0;
    sq_if.i_alloc_addr     = '0;
    sq_if.i_alloc_data     = '0;
    sq_if.i_alloc_byte_sel = '0;
    sq_if.i_rob_retire_en  = 1'b0;
    sq_if.i_rob_retire_tag = '0;
    sq_if.i_retire_stall   = 1'b0;
    sq_if.i_fwd_en         = 1'b0;
    sq_if.i_fwd_addr       = '0;
    sq_if.i_fwd_byte_sel   = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic alloc_set(input int unsigned tag, input logic [31:0] addr,
                           input logic [31:0] data, input logic [3:0] sel);
    sq_if.i_alloc_en       = 1'b1;
    sq_if.i_alloc_tag      = TAG_WIDTH'(tag);
    sq_if.i_alloc_addr     = addr;
    sq_if.i_alloc_data     = data;
    sq_if.i_alloc_byte_sel = sel;
  endtask

  task automatic commit(input int unsigned tag);
    sq_if.i_rob_retire_en  = 1'b1;
    sq_if.i_rob_retire_tag = TAG_WIDTH'(tag);
  endtask

  task automatic load(input logic [31:0] addr, input logic [3:0] sel);
    sq_if.i_fwd_en       = 1'b1;
    sq_if.i_fwd_addr     = addr;
    sq_if.i_fwd_byte_sel = sel;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    do_reset();
    load(32'h100, 4'hF);
    #1;
    check("rst_empty", sq_if.o_empty, 1);
    check("rst_full", sq_if.o_full, 0);
    check("rst_retire_en", sq_if.o_retire_en, 0);
    check("rst_fwd_hit", sq_if.o_fwd_hit, 0);
    check("rst_fwd_conflict", sq_if.o_fwd_conflict, 0);

    // Fill to full with uncommitted stores
    for (int i = 0; i < 8; i++) begin
      alloc_set(i, 32'h100 + 4 * i, 32'hA0 + i, 4'hF);
      tick();
      check("fill_full", sq_if.o_full, (i == 7) ? 1 : 0);
      check("fill_retire_en", sq_if.o_retire_en, 0);
    end
    alloc_set(8, 32'h500, 32'hDEAD, 4'hF);
    tick();
    sq_if.i_alloc_en = 1'b0;
    load(32'h500, 4'hF);
    #1;
    check("full_drop_full", sq_if.o_full, 1);
    check("full_drop_fwd", sq_if.o_fwd_hit, 0);
    load(32'h11C, 4'hF);
    #1;
    check("full_last_hit", sq_if.o_fwd_hit, 1);
    check("full_last_data", sq_if.o_fwd_data, 32'hA7);

    // Commit head under stall; held stable three cycles
    commit(0);
    sq_if.i_retire_stall = 1'b1;
    tick();
    sq_if.i_rob_retire_en = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("stall_retire_en", sq_if.o_retire_en, 1);
      check("stall_retire_addr", sq_if.o_retire_addr, 32'h100);
      check("stall_retire_data", sq_if.o_retire_data, 32'hA0);
      tick();
    end
    // Release stall with an alloc that must still be dropped (queue full at the edge)
    sq_if.i_retire_stall = 1'b0;
    alloc_set(9, 32'h504, 32'hBEEF, 4'hF);
    #1;
    check("drain_pre_full", sq_if.o_full, 1);
    tick();
    sq_if.i_alloc_en = 1'b0;
    load(32'h504, 4'hF);
    #1;
    check("drain_full_clear", sq_if.o_full, 0);
    check("drain_empty", sq_if.o_empty, 0);
    check("drain_retire_en", sq_if.o_retire_en, 0);
    check("drain_dropped_alloc", sq_if.o_fwd_hit, 0);
    load(32'h100, 4'hF);
    #1;
    check("drained_not_visible", sq_if.o_fwd_hit, 0);

    // Forwarding: youngest store wins; allocating entry not yet visible
    do_reset();
    alloc_set(1, 32'h200, 32'h11111111, 4'hF);
    tick();
    alloc_set(2, 32'h200, 32'h22222222, 4'hF);
    load(32'h200, 4'hF);
    #1;
    check("fwd_pre_hit", sq_if.o_fwd_hit, 1);
    check("fwd_pre_data", sq_if.o_fwd_data, 32'h11111111);
    tick();
    sq_if.i_alloc_en = 1'b0;
    #1;
    check("fwd_young_hit", sq_if.o_fwd_hit, 1);
    check("fwd_young_data", sq_if.o_fwd_data, 32'h22222222);
    check("fwd_young_conflict", sq_if.o_fwd_conflict, 0);

    // Partial overlap / subset / miss
    alloc_set(3, 32'h300, 32'h0000BEEF, 4'b0011);
    tick();
    sq_if.i_alloc_en = 1'b0;
    load(32'h300, 4'hF);
    #1;
    check("part_conflict", sq_if.o_fwd_conflict, 1);
    check("part_hit", sq_if.o_fwd_hit, 0);
    load(32'h300, 4'b0001);
    #1;
    check("sub_hit", sq_if.o_fwd_hit, 1);
    check("sub_data", sq_if.o_fwd_data, 32'h0000BEEF);
    check("sub_conflict", sq_if.o_fwd_conflict, 0);
    load(32'h302, 4'b0010);
    #1;
    check("word_ofs_hit", sq_if.o_fwd_hit, 1);
    load(32'h304, 4'hF);
    #1;
    check("miss_hit", sq_if.o_fwd_hit, 0);
    check("miss_conflict", sq_if.o_fwd_conflict, 0);
    load(32'h200, 4'b1100);
    #1;
    check("upper_lane_data", sq_if.o_fwd_data, 32'h22222222);
    check("upper_lane_hit", sq_if.o_fwd_hit, 1);
    load(32'h300, 4'b0001);
    sq_if.i_fwd_en = 1'b0;
    #1;
    check("fwd_dis_hit", sq_if.o_fwd_hit, 0);

    // Flush with same-cycle alloc and commit of tag 2
    do_reset();
    for (int i = 0; i < 5; i++) begin
      alloc_set(i, 32'h400 + 4 * i, 32'hC0 + i, 4'hF);
      tick();
    end
    sq_if.i_alloc_en = 1'b0;
    sq_if.i_retire_stall = 1'b1;
    commit(0);
    tick();
    commit(1);
    tick();
    sq_if.i_flush = 1'b1;
    alloc_set(9, 32'h4F0, 32'h99, 4'hF);
    commit(2);
    tick();
    idle();
    sq_if.i_retire_stall = 1'b1;
    load(32'h4F0, 4'hF);
    #1;
    check("flush_alloc_gone", sq_if.o_fwd_hit, 0);
    load(32'h408, 4'hF);
    #1;
    check("flush_tag2_hit", sq_if.o_fwd_hit, 1);
    check("flush_tag2_data", sq_if.o_fwd_data, 32'hC2);
    load(32'h40C, 4'hF);
    #1;
    check("flush_tag3_gone", sq_if.o_fwd_hit, 0);
    check("flush_empty", sq_if.o_empty, 0);
    sq_if.i_retire_stall = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("flush_drain_en", sq_if.o_retire_en, 1);
      check("flush_drain_tag", sq_if.o_retire_tag, k);
      tick();
    end
    #1;
    check("flush_after_empty", sq_if.o_empty, 1);
    check("flush_after_retire", sq_if.o_retire_en, 0);
    alloc_set(5, 32'h480, 32'h55, 4'hF);
    tick();
    sq_if.i_alloc_en = 1'b0;
    load(32'h480, 4'hF);
    #1;
    check("flush_new_hit", sq_if.o_fwd_hit, 1);
    check("flush_new_data", sq_if.o_fwd_data, 32'h55);
    check("flush_new_empty", sq_if.o_empty, 0);

    // Sustained alloc+drain across the pointer wrap
    do_reset();
    sq_if.i_retire_stall = 1'b1;
    alloc_set(0, 32'h600, 32'hE000, 4'hF);
    tick();
    alloc_set(1, 32'h600, 32'hE001, 4'hF);
    commit(0);
    tick();
    alloc_set(2, 32'h600, 32'hE002, 4'hF);
    commit(1);
    tick();
    sq_if.i_retire_stall = 1'b0;
    for (int k = 0; k < 20; k++) begin
      alloc_set(3 + k, 32'h600, 32'hE003 + k, 4'hF);
      commit(2 + k);
      load(32'h600, 4'hF);
      #1;
      check("wrap_retire_en", sq_if.o_retire_en, 1);
      check("wrap_retire_tag", sq_if.o_retire_tag, k);
      check("wrap_retire_data", sq_if.o_retire_data, 32'hE000 + k);
      check("wrap_fwd_hit", sq_if.o_fwd_hit, 1);
      check("wrap_fwd_data", sq_if.o_fwd_data, 32'hE002 + k);
      check("wrap_full", sq_if.o_full, 0);
      tick();
    end
    sq_if.i_alloc_en = 1'b0;
    commit(22);
    for (int k = 20; k < 23; k++) begin
      #1;
      check("wrap_tail_en", sq_if.o_retire_en, 1);
      check("wrap_tail_tag", sq_if.o_retire_tag, k);
      tick();
      sq_if.i_rob_retire_en = 1'b0;
    end
    #1;
    check("wrap_final_empty", sq_if.o_empty, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
